// File: rtl/i8088_bus_pkg.sv
// -----------------------------------------------------------------------------
// i8088_bus_pkg
// Shared definitions for the 8088 local-bus initiator and the responder-side
// models. The bus-state enum is used by both sides.
//   bus_state_t     : IDLE, T1, T2, T3, TW, T4
//   TIMEOUT_DATA    : read data returned when a cycle is aborted by timeout
//   wait_cnt_width  : width of the wait-state counter for a given timeout
// -----------------------------------------------------------------------------
package i8088_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      T1,
      T2,
      T3,
      TW,
      T4
   } bus_state_t;

   localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

   // Enough bits to hold TIMEOUT_CYCLES itself; a disabled timeout (0) still
   // gets a 1-bit counter so the timer never degenerates to zero width.
   function automatic int wait_cnt_width(input int timeout_cycles);
      return (timeout_cycles <= 0) ? 1 : $clog2(timeout_cycles + 1);
   endfunction

endpackage

// File: rtl/i8088_wait_timer.sv
// -----------------------------------------------------------------------------
// i8088_wait_timer
// Saturating wait-state counter. Cleared at the start of every bus cycle,
// advanced once per TW state, and flags when the programmed timeout is hit.
//   clk     in  bus clock
//   rst_n   in  asynchronous active-low reset
//   clear   in  synchronous clear (takes priority over enable)
//   enable  in  count one wait state
//   tc      out terminal count: counter equals TIMEOUT_CYCLES (never when 0)
// -----------------------------------------------------------------------------
module i8088_wait_timer
   import i8088_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam int              CNT_W   = wait_cnt_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt;

   // NOTE: clocked state uses non-blocking (<=) so every register samples the
   // pre-edge values of its inputs regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && (cnt != CNT_MAX)) begin
         // Saturate at all-ones so a long stall can never wrap back to 0.
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tc = (TIMEOUT_CYCLES != 0) && (cnt == TC_VAL);

endmodule

// File: rtl/i8088_bus_initiator.sv
// -----------------------------------------------------------------------------
// i8088_bus_initiator
// Bus-master engine for the multiplexed 8088 local bus. Takes single-byte
// memory / I/O read / write requests on a valid/ready port and runs the
// matching T1..T4 cycle, inserting TW states while READY is low. Every bus
// output is a register; one T-state is one I8088_CLK period.
//   I8088_CLK, RESETN            bus clock, async active-low reset
//   req_valid/req_ready          request handshake
//   req_addr/write/io/wdata      request fields (I/O uses addr[15:0] only)
//   rsp_valid/rsp_rdata/rsp_err  one-cycle completion (err = timeout)
//   A19_8, AD_out, AD_oe, AD_in  address / multiplexed address-data bus
//   ALE, nRD, nWR, IO_nM,
//   DT_nR, nDEN                  minimum-mode strobes
//   READY                        slave ready, already synchronous to I8088_CLK
// -----------------------------------------------------------------------------
module i8088_bus_initiator
   import i8088_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        I8088_CLK,
   input  logic        RESETN,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [19:0] req_addr,
   input  logic        req_write,
   input  logic        req_io,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_err,
   output logic [11:0] A19_8,
   output logic [7:0]  AD_out,
   output logic        AD_oe,
   input  logic [7:0]  AD_in,
   output logic        ALE,
   output logic        nRD,
   output logic        nWR,
   output logic        IO_nM,
   output logic        DT_nR,
   output logic        nDEN,
   input  logic        READY
);

   bus_state_t state;
   logic       write_q;
   logic [7:0] wdata_q;
   logic       timer_tc;

   // Address and cycle type go straight into the A19_8 / AD_out / IO_nM
   // output registers at acceptance, so only the write flag and write data
   // need a separate holding register for T2 onwards.

   i8088_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk    (I8088_CLK),
      .rst_n  (RESETN),
      .clear  (state == T1),
      .enable (((state == T3) || (state == TW)) && !READY),
      .tc     (timer_tc)
   );

   // A new request can be taken in T4, which is what makes back-to-back
   // cycles run without an idle gap.
   assign req_ready = (state == IDLE) || (state == T4);

   always_ff @(posedge I8088_CLK or negedge RESETN) begin
      if (!RESETN) begin
         state     <= IDLE;
         write_q   <= 1'b0;
         wdata_q   <= 8'h00;
         rsp_valid <= 1'b0;
         rsp_rdata <= 8'h00;
         rsp_err   <= 1'b0;
         A19_8     <= 12'h000;
         AD_out    <= 8'h00;
         AD_oe     <= 1'b0;
         ALE       <= 1'b0;
         nRD       <= 1'b1;
         nWR       <= 1'b1;
         IO_nM     <= 1'b0;
         DT_nR     <= 1'b0;
         nDEN      <= 1'b1;
      end else begin
         // Completion is a single-cycle pulse; only the T4 entry raises it.
         rsp_valid <= 1'b0;

         case (state)
            IDLE, T4: begin
               if (req_valid) begin
                  state   <= T1;
                  write_q <= req_write;
                  wdata_q <= req_wdata;
                  ALE     <= 1'b1;
                  A19_8   <= req_io ? {4'h0, req_addr[15:8]} : req_addr[19:8];
                  AD_out  <= req_addr[7:0];
                  AD_oe   <= 1'b1;
                  IO_nM   <= req_io;
                  DT_nR   <= req_write;
               end else begin
                  state <= IDLE;
               end
            end

            T1: begin
               state <= T2;
               ALE   <= 1'b0;
               nDEN  <= 1'b0;
               if (write_q) begin
                  AD_out <= wdata_q;
                  AD_oe  <= 1'b1;
                  nWR    <= 1'b0;
               end else begin
                  // Release AD on the same edge nRD asserts so the slave
                  // never fights the address phase.
                  AD_oe <= 1'b0;
                  nRD   <= 1'b0;
               end
            end

            T2: begin
               state <= T3;
            end

            T3, TW: begin
               if (READY || timer_tc) begin
                  // READY wins over a coincident timeout.
                  state     <= T4;
                  nRD       <= 1'b1;
                  nWR       <= 1'b1;
                  nDEN      <= 1'b1;
                  AD_oe     <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= !READY;
                  if (!READY) begin
                     rsp_rdata <= TIMEOUT_DATA;
                  end else if (write_q) begin
                     rsp_rdata <= 8'h00;
                  end else begin
                     rsp_rdata <= AD_in;
                  end
               end else begin
                  state <= TW;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i8088_bus_initiator.sv
// -----------------------------------------------------------------------------
// tb_i8088_bus_initiator
// Directed bench: a driver issues requests from a table, pushing each
// hand-computed response into a scoreboard queue; a monitor pops and compares
// on every rsp_valid, follows the T-state sequence of the current cycle and
// checks the strobe invariants. A simple slave model drives READY / AD_in.
// -----------------------------------------------------------------------------
module tb_i8088_bus_initiator;

   localparam int TO = 4;

   logic        I8088_CLK = 1'b0;
   logic        RESETN    = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [19:0] req_addr  = '0;
   logic        req_write = 1'b0;
   logic        req_io    = 1'b0;
   logic [7:0]  req_wdata = '0;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic [11:0] A19_8;
   logic [7:0]  AD_out;
   logic        AD_oe;
   logic [7:0]  AD_in = 8'h00;
   logic        ALE, nRD, nWR, IO_nM, DT_nR, nDEN;
   logic        READY = 1'b1;

   always #5 I8088_CLK = ~I8088_CLK;

   i8088_bus_initiator #(.TIMEOUT_CYCLES(TO)) dut (
      .I8088_CLK (I8088_CLK),
      .RESETN    (RESETN),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_write (req_write),
      .req_io    (req_io),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .A19_8     (A19_8),
      .AD_out    (AD_out),
      .AD_oe     (AD_oe),
      .AD_in     (AD_in),
      .ALE       (ALE),
      .nRD       (nRD),
      .nWR       (nWR),
      .IO_nM     (IO_nM),
      .DT_nR     (DT_nR),
      .nDEN      (nDEN),
      .READY     (READY)
   );

   typedef struct {
      logic [19:0] addr;
      logic        write;
      logic        io;
      logic [7:0]  wdata;
      logic [7:0]  ad;        // slave read data at the READY edge
      int          waits;     // READY-low edges the slave inserts
      logic [11:0] exp_a;     // expected A19_8
      logic [7:0]  exp_rdata;
      logic        exp_err;
      int          exp_tw;    // expected number of TW states
   } vec_t;

   typedef struct packed {
      logic [7:0] rdata;
      logic       err;
   } rsp_t;

   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   rsp_t sb_q[$];
   int   sl_wait_q[$];
   logic [7:0] sl_data_q[$];

   vec_t cur;
   bit   trk_active = 0;
   int   trk_cyc    = 0;
   int   acc_time   = 0;

   vec_t vecs[11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ALE nRD nWR nDEN IO_nM DT_nR AD_oe AD_out A19_8 rsp_valid rsp_rdata rsp_err req_ready
   task automatic check_reset_vals(input string name);
      check(name, {ALE, nRD, nWR, nDEN, IO_nM, DT_nR, AD_oe, AD_out, A19_8,
                   rsp_valid, rsp_rdata, rsp_err, req_ready},
            {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000,
             1'b0, 8'h00, 1'b0, 1'b1});
   endtask

   always @(posedge I8088_CLK) cyc++;

   // Slave model: counts strobe-low cycles (1 = T2, 2 = T3, ...). READY is
   // held low for `waits` sampled edges from T3 on; AD_in carries junk until
   // the edge on which READY is finally high.
   int         sl_k = 0;
   int         sl_w = 0;
   logic [7:0] sl_d = 8'h00;
   always @(negedge I8088_CLK) begin
      if (!nRD || !nWR) begin
         sl_k++;
         if (sl_k == 1) begin
            sl_w = (sl_wait_q.size() != 0) ? sl_wait_q.pop_front() : 0;
            sl_d = (sl_data_q.size() != 0) ? sl_data_q.pop_front() : 8'h00;
         end
         if (sl_k >= 2 + sl_w) begin
            READY = 1'b1;
            AD_in = sl_d;
         end else begin
            READY = 1'b0;
            AD_in = 8'(8'h10 + sl_k);
         end
      end else begin
         sl_k  = 0;
         READY = 1'b1;
         AD_in = 8'h00;
      end
   end

   // Monitor: invariants, scoreboard and per-cycle phase tracking.
   always @(negedge I8088_CLK) begin
      if (RESETN) begin
         check("strobe_overlap", !nRD && !nWR, 1'b0);
         check("ale_overlap", ALE && (!nRD || !nWR || !nDEN), 1'b0);

         if (rsp_valid) begin
            if (sb_q.size() == 0) begin
               check("unexpected_rsp", rsp_valid, 1'b0);
            end else begin
               rsp_t e;
               e = sb_q.pop_front();
               check("rsp_rdata", rsp_rdata, e.rdata);
               check("rsp_err", rsp_err, e.err);
            end
         end

         if (trk_active) begin
            trk_cyc++;
            if (trk_cyc == 1) begin
               check("t1_bus", {ALE, A19_8, AD_out, AD_oe, IO_nM, DT_nR, nRD, nWR, nDEN, req_ready},
                     {1'b1, cur.exp_a, cur.addr[7:0], 1'b1, cur.io, cur.write, 3'b111, 1'b0});
            end else if (trk_cyc < 4 + cur.exp_tw) begin
               if (cur.write)
                  check("data_phase_wr", {ALE, nDEN, rsp_valid, AD_oe, AD_out, nWR, nRD, A19_8},
                        {3'b000, 1'b1, cur.wdata, 1'b0, 1'b1, cur.exp_a});
               else
                  check("data_phase_rd", {ALE, nDEN, rsp_valid, AD_oe, nRD, nWR, A19_8},
                        {3'b000, 1'b0, 1'b0, 1'b1, cur.exp_a});
            end else begin
               check("t4_bus", {rsp_valid, nRD, nWR, nDEN, AD_oe, req_ready, A19_8, IO_nM, DT_nR},
                     {1'b1, 3'b111, 1'b0, 1'b1, cur.exp_a, cur.io, cur.write});
               trk_active = 0;
            end
         end
      end
   end

   task automatic send(input vec_t v, input bit expect_rsp);
      int guard = 0;
      @(negedge I8088_CLK);
      while (!req_ready && guard < 200) begin
         @(negedge I8088_CLK);
         guard++;
      end
      if (guard >= 200) begin
         check("req_ready_wait", req_ready, 1'b1);
         return;
      end
      req_valid = 1'b1;
      req_addr  = v.addr;
      req_write = v.write;
      req_io    = v.io;
      req_wdata = v.wdata;
      if (expect_rsp) sb_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
      sl_wait_q.push_back(v.waits);
      sl_data_q.push_back(v.ad);
      @(posedge I8088_CLK);
      cur        = v;
      trk_cyc    = 0;
      trk_active = expect_rsp;
      acc_time   = cyc;
      #1;
      req_valid = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
   endtask

   task automatic wait_idle();
      int g = 0;
      while ((sb_q.size() != 0 || trk_active) && g < 300) begin
         @(negedge I8088_CLK);
         g++;
      end
      if (g >= 300) check("drain", sb_q.size(), 0);
      repeat (2) @(negedge I8088_CLK);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1);
   end

   initial begin
      int t_first;
      //            addr      wr    io    wdata  ad     waits exp_a    rdata  err   tw
      vecs[0]  = '{20'hFFFF0, 1'b0, 1'b0, 8'h00, 8'hEA, 0,  12'hFFF, 8'hEA, 1'b0, 0};
      vecs[1]  = '{20'h003F8, 1'b1, 1'b1, 8'h55, 8'h00, 0,  12'h003, 8'h00, 1'b0, 0};
      vecs[2]  = '{20'h12345, 1'b0, 1'b0, 8'h00, 8'hC3, 3,  12'h123, 8'hC3, 1'b0, 3};
      vecs[3]  = '{20'h0ABCD, 1'b0, 1'b0, 8'h00, 8'h66, 99, 12'h0AB, 8'hFF, 1'b1, 4};
      vecs[4]  = '{20'hA0060, 1'b0, 1'b1, 8'h00, 8'h7E, 0,  12'h000, 8'h7E, 1'b0, 0};
      vecs[5]  = '{20'h80000, 1'b0, 1'b0, 8'h00, 8'h3C, 0,  12'h800, 8'h3C, 1'b0, 0};
      vecs[6]  = '{20'h80001, 1'b1, 1'b0, 8'hA5, 8'h00, 0,  12'h800, 8'h00, 1'b0, 0};
      vecs[7]  = '{20'h7FFFF, 1'b1, 1'b0, 8'h5A, 8'h00, 99, 12'h7FF, 8'hFF, 1'b1, 4};
      vecs[8]  = '{20'h00100, 1'b0, 1'b0, 8'h00, 8'h99, 4,  12'h001, 8'h99, 1'b0, 4};
      vecs[9]  = '{20'h45678, 1'b0, 1'b0, 8'h00, 8'h77, 99, 12'h456, 8'hFF, 1'b1, 4};
      vecs[10] = '{20'h00080, 1'b1, 1'b1, 8'h0F, 8'h00, 2,  12'h000, 8'h00, 1'b0, 2};

      // Reset state.
      #1 RESETN = 1'b0;
      #1 check_reset_vals("reset_values");
      repeat (3) @(negedge I8088_CLK);
      check_reset_vals("reset_values_clocked");
      RESETN = 1'b1;

      // Isolated cycles: zero-wait read, I/O write, waits, timeout, recovery.
      for (int i = 0; i <= 4; i++) begin
         send(vecs[i], 1'b1);
         wait_idle();
      end

      // Back-to-back read then write: second T1 right after first T4.
      send(vecs[5], 1'b1);
      t_first = acc_time;
      send(vecs[6], 1'b1);
      check("b2b_gap", acc_time - t_first, 4);
      wait_idle();

      // Write timeout, then READY arriving on the timeout edge.
      send(vecs[7], 1'b1);
      wait_idle();
      send(vecs[8], 1'b1);
      wait_idle();

      // Reset during TW: accept, then drop RESETN in the second TW.
      send(vecs[9], 1'b0);
      repeat (5) @(negedge I8088_CLK);
      check("pre_reset_in_tw", {nRD, READY}, 2'b00);
      #2 RESETN = 1'b0;
      #1 check_reset_vals("reset_mid_cycle");
      repeat (2) @(negedge I8088_CLK);
      check("no_rsp_in_reset", rsp_valid, 1'b0);
      RESETN = 1'b1;
      #1 check("ready_after_reset", req_ready, 1'b1);
      repeat (3) @(negedge I8088_CLK);
      check_reset_vals("idle_after_reset");

      // Normal traffic after the aborted cycle.
      send(vecs[10], 1'b1);
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
